mem_tile_reader: RTL and testbench

Streams a rectangular tile out of the image `Memory` into the convolution datapath. It sits directly downstream of `Memory` and drives both of its read ports, so two horizontally adjacent pixels are fetched per cycle. It absorbs the memory's 1-cycle registered read latency and presents a valid/ready pixel-pair stream to the consumer, with full-rate throughput and lossless backpressure.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/pair_fifo.sv | 49 ++++
 rtl/mem_tile_reader.sv | 194 +++++++++++++++++++
 tb/tb_mem_tile_reader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types for the convolution front end: FSM states and the pixel-pair
// FIFO entry carried from the memory tile reader to the datapath.
package conv_pkg;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 18;
   localparam int DIM_W      = 11;
   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] data_a;
      logic [DATA_W-1:0] data_b;
      logic              b_valid;
      logic              eol;
      logic              last;
   } fifo_entry_t;

endpackage

// File: rtl/pair_fifo.sv
// Four-entry pixel-pair FIFO; head is visible combinationally, and a push
// and pop in the same cycle are both honoured when the FIFO is non-empty.
module pair_fifo
   import conv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  fifo_entry_t           din_i,
   input  logic                  pop_i,
   output fifo_entry_t           dout_o,
   output logic [FIFO_CNT_W-1:0] count_o
);

   fifo_entry_t             mem_q [FIFO_DEPTH];
   logic [1:0]              wr_q, wr_d, rd_q, rd_d;
   logic [FIFO_CNT_W-1:0]   cnt_q, cnt_d;
   logic                    do_push, do_pop;

   always_comb begin
      do_pop  = pop_i && (cnt_q != '0);
      do_push = push_i && ((cnt_q != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);
      wr_d    = do_push ? wr_q + 2'd1 : wr_q;
      rd_d    = do_pop  ? rd_q + 2'd1 : rd_q;
      cnt_d   = cnt_q + {{(FIFO_CNT_W-1){1'b0}}, do_push}
                      - {{(FIFO_CNT_W-1){1'b0}}, do_pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the top gates the head with the count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/mem_tile_reader.sv
// Streams a rectangular tile out of the dual-read-port image memory as
// left/right pixel pairs, hiding the 1-cycle read latency behind a small FIFO.
module mem_tile_reader #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 18,
   parameter int DIM_W  = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] pitch,
   input  logic [DIM_W-1:0]  width,
   input  logic [DIM_W-1:0]  height,
   output logic [ADDR_W-1:0] read_addr_a,
   output logic [ADDR_W-1:0] read_addr_b,
   input  logic [DATA_W-1:0] read_data_a,
   input  logic [DATA_W-1:0] read_data_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data_a,
   output logic [DATA_W-1:0] out_data_b,
   output logic              out_b_valid,
   output logic              out_eol,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   import conv_pkg::state_e;
   import conv_pkg::fifo_entry_t;

   localparam logic [DIM_W-1:0]  D_ONE  = DIM_W'(1);
   localparam logic [DIM_W-1:0]  D_TWO  = DIM_W'(2);
   localparam logic [DIM_W:0]    D_TWOX = (DIM_W+1)'(2);
   localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   row_addr_q, row_addr_d;
   logic [ADDR_W-1:0]   pitch_q, pitch_d;
   logic [DIM_W-1:0]    width_q, width_d;
   logic [DIM_W-1:0]    height_q, height_d;
   logic [DIM_W-1:0]    col_q, col_d;
   logic [DIM_W-1:0]    row_q, row_d;
   logic [ADDR_W-1:0]   last_a_q, last_a_d;
   logic [ADDR_W-1:0]   last_b_q, last_b_d;
   logic                infl_q, infl_d;
   logic                bv_q, bv_d;
   logic                eol_q, eol_d;
   logic                lst_q, lst_d;
   logic                done_q, done_d;

   logic [ADDR_W-1:0]   addr_a, addr_b;
   logic                tail, eol, last_pair, credit_ok, issue, pop;
   fifo_entry_t         push_entry, head;
   logic [2:0]          fifo_cnt;

   // Current pair's addresses and tags, derived from the column/row counters.
   always_comb begin
      addr_a    = row_addr_q + ADDR_W'(col_q);
      tail      = (col_q == width_q - D_ONE);
      addr_b    = tail ? addr_a : addr_a + A_ONE;
      eol       = (({1'b0, col_q} + D_TWOX) >= {1'b0, width_q});
      last_pair = eol && (row_q == height_q - D_ONE);
      // One read may still be returning, so keep FIFO + in-flight below 3.
      credit_ok = (fifo_cnt + {2'b00, infl_q}) <= 3'd2;
   end

   always_comb begin
      state_d    = state_q;
      row_addr_d = row_addr_q;
      pitch_d    = pitch_q;
      width_d    = width_q;
      height_d   = height_q;
      col_d      = col_q;
      row_d      = row_q;
      last_a_d   = last_a_q;
      last_b_d   = last_b_q;
      bv_d       = bv_q;
      eol_d      = eol_q;
      lst_d      = lst_q;
      done_d     = 1'b0;
      issue      = 1'b0;
      unique case (state_q)
         conv_pkg::IDLE: begin
            if (start) begin
               if ((width != '0) && (height != '0)) begin
                  state_d    = conv_pkg::FETCH;
                  row_addr_d = base_addr;
                  pitch_d    = pitch;
                  width_d    = width;
                  height_d   = height;
                  col_d      = '0;
                  row_d      = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         conv_pkg::FETCH: begin
            if (credit_ok) begin
               issue    = 1'b1;
               last_a_d = addr_a;
               last_b_d = addr_b;
               bv_d     = ~tail;
               eol_d    = eol;
               lst_d    = last_pair;
               if (eol) begin
                  col_d      = '0;
                  row_d      = row_q + D_ONE;
                  row_addr_d = row_addr_q + pitch_q;
               end else begin
                  col_d = col_q + D_TWO;
               end
               if (last_pair) state_d = conv_pkg::DRAIN;
            end
         end
         conv_pkg::DRAIN: begin
            if (pop && head.last) begin
               state_d = conv_pkg::IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = conv_pkg::IDLE;
      endcase
   end

   assign infl_d = issue;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= conv_pkg::IDLE;
         row_addr_q <= '0;
         pitch_q    <= '0;
         width_q    <= '0;
         height_q   <= '0;
         col_q      <= '0;
         row_q      <= '0;
         last_a_q   <= '0;
         last_b_q   <= '0;
         infl_q     <= 1'b0;
         bv_q       <= 1'b0;
         eol_q      <= 1'b0;
         lst_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_addr_q <= row_addr_d;
         pitch_q    <= pitch_d;
         width_q    <= width_d;
         height_q   <= height_d;
         col_q      <= col_d;
         row_q      <= row_d;
         last_a_q   <= last_a_d;
         last_b_q   <= last_b_d;
         infl_q     <= infl_d;
         bv_q       <= bv_d;
         eol_q      <= eol_d;
         lst_q      <= lst_d;
         done_q     <= done_d;
      end
   end

   // Read ports show the live pair when issuing, otherwise hold the last one.
   assign read_addr_a = issue ? addr_a : last_a_q;
   assign read_addr_b = issue ? addr_b : last_b_q;

   assign push_entry = '{data_a:  read_data_a,
                         data_b:  read_data_b,
                         b_valid: bv_q,
                         eol:     eol_q,
                         last:    lst_q};

   pair_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (infl_q),
      .din_i   (push_entry),
      .pop_i   (pop),
      .dout_o  (head),
      .count_o (fifo_cnt)
   );

   assign out_valid   = (fifo_cnt != 3'd0);
   assign pop         = out_valid && out_ready;
   assign out_data_a  = out_valid ? head.data_a : '0;
   assign out_data_b  = out_valid ? head.data_b : '0;
   assign out_b_valid = out_valid && head.b_valid;
   assign out_eol     = out_valid && head.eol;
   assign out_last    = out_valid && head.last;
   assign busy        = (state_q != conv_pkg::IDLE);
   assign done        = done_q;

endmodule

// File: tb/tb_mem_tile_reader.sv
// Scoreboard bench for mem_tile_reader: directed tiles push expected pairs,
// a negedge monitor pops and compares every accepted output pair.
module tb_mem_tile_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0, pitch = '0;
   logic [10:0] width = '0, height = '0;
   logic [15:0] read_addr_a, read_addr_b;
   logic [17:0] read_data_a = '0, read_data_b = '0;
   logic        out_valid, out_ready = 1'b1;
   logic [17:0] out_data_a, out_data_b;
   logic        out_b_valid, out_eol, out_last, busy, done;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bv;
      logic        eol;
      logic        last;
   } pair_t;

   pair_t exp_q[$];
   int    n_chk = 0, n_pass = 0, done_cnt = 0;
   bit    rand_rdy = 1'b0;

   always #5 clk = ~clk;

   mem_tile_reader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .pitch       (pitch),
      .width       (width),
      .height      (height),
      .read_addr_a (read_addr_a),
      .read_addr_b (read_addr_b),
      .read_data_a (read_data_a),
      .read_data_b (read_data_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data_a  (out_data_a),
      .out_data_b  (out_data_b),
      .out_b_valid (out_b_valid),
      .out_eol     (out_eol),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done)
   );

   function automatic logic [17:0] mem_f(input logic [15:0] a);
      return {a[7:0], ~a[15:8], 2'b10};
   endfunction

   // Memory with one-cycle registered read on both ports.
   always @(posedge clk) begin
      read_data_a <= mem_f(read_addr_a);
      read_data_b <= mem_f(read_addr_b);
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_pair(input logic [15:0] a, b, input logic bv, eol, last);
      pair_t p;
      p.a = a; p.b = b; p.bv = bv; p.eol = eol; p.last = last;
      exp_q.push_back(p);
   endtask

   task automatic exp_tile(input logic [15:0] base, pit, input int w, h);
      logic [15:0] ra;
      logic [15:0] a;
      ra = base;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c += 2) begin
            a = ra + 16'(c);
            if (c + 1 < w) exp_pair(a, a + 16'd1, 1'b1, c + 2 >= w, (c + 2 >= w) && (r == h - 1));
            else           exp_pair(a, a, 1'b0, 1'b1, r == h - 1);
         end
         ra = ra + pit;
      end
   endtask

   task automatic launch(input logic [15:0] b, p, input logic [10:0] w, h);
      base_addr = b; pitch = p; width = w; height = h;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < lim) begin
         tick();
         n++;
      end
      chk("idle_reached", n < lim, 1);
      tick();
      tick();
   endtask

   initial begin : ready_gen
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin : monitor
      pair_t       e;
      bit          chk_done, hold;
      logic [38:0] snap;
      chk_done = 1'b0;
      hold     = 1'b0;
      snap     = '0;
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (chk_done) begin
            chk("done_after_last", {done, busy}, 2'b10);
            chk_done = 1'b0;
         end
         if (hold)
            chk("stall_stable", {out_valid, out_data_a, out_data_b, out_b_valid, out_eol, out_last},
                {1'b1, snap});
         hold = rst_n && out_valid && !out_ready;
         snap = {out_data_a, out_data_b, out_b_valid, out_eol, out_last};
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pair", {out_data_a, out_data_b}, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pair", {out_data_a, out_data_b, out_b_valid, out_eol, out_last},
                   {mem_f(e.a), mem_f(e.b), e.bv, e.eol, e.last});
            end
            if (out_last) chk_done = 1'b1;
         end
      end
   end

   initial begin : stim
      int n, d0;
      bit seen;

      tick(); tick();
      chk("reset_addr", {read_addr_a, read_addr_b}, 0);
      chk("reset_outs", {out_valid, out_data_a, out_data_b, out_b_valid, out_eol, out_last, busy, done}, 0);
      rst_n = 1'b1;
      tick();

      // Basic 4x2 tile: latency 2, full rate, done after final pop
      exp_pair(16'd100, 16'd101, 1, 0, 0);
      exp_pair(16'd102, 16'd103, 1, 1, 0);
      exp_pair(16'd110, 16'd111, 1, 0, 0);
      exp_pair(16'd112, 16'd113, 1, 1, 1);
      d0 = done_cnt;
      launch(16'd100, 16'd10, 11'd4, 11'd2);
      chk("busy_after_start", {busy, out_valid}, 2'b10);
      tick(); chk("lat_e1_valid", out_valid, 0);
      tick(); chk("lat_e2_valid", out_valid, 1);
      n = 0;
      while (!done && n < 20) begin tick(); n++; end
      chk("tile_a_cycles_to_done", n, 4);
      wait_idle(50);
      chk("tile_a_done_count", done_cnt - d0, 1);

      // Odd width tail
      exp_pair(16'd0, 16'd1, 1, 0, 0);
      exp_pair(16'd2, 16'd2, 0, 1, 1);
      launch(16'd0, 16'd8, 11'd3, 11'd1);
      tick();
      chk("odd_first_addr", {read_addr_a, read_addr_b}, {16'd2, 16'd2});
      wait_idle(50);

      // Random backpressure on a 16x4 tile
      exp_tile(16'd1000, 16'd32, 16, 4);
      rand_rdy = 1'b1;
      launch(16'd1000, 16'd32, 11'd16, 11'd4);
      wait_idle(1000);
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      tick();

      // Zero-sized tiles complete immediately
      d0 = done_cnt;
      launch(16'd0, 16'd4, 11'd4, 11'd0);
      chk("zero_h_done", {done, busy}, 2'b10);
      tick();
      chk("zero_h_once", {done, busy, out_valid}, 0);
      launch(16'd0, 16'd4, 11'd0, 11'd3);
      chk("zero_w_done", {done, busy}, 2'b10);
      tick(); tick();
      chk("zero_done_count", done_cnt - d0, 2);

      // Start mid-tile is ignored
      exp_tile(16'd300, 16'd16, 6, 2);
      d0 = done_cnt;
      launch(16'd300, 16'd16, 11'd6, 11'd2);
      tick(); tick();
      launch(16'd900, 16'd1, 11'd2, 11'd1);
      wait_idle(100);
      chk("midstart_done_count", done_cnt - d0, 1);

      // Address wrap
      exp_pair(16'd65534, 16'd65535, 1, 0, 0);
      exp_pair(16'd0, 16'd1, 1, 1, 1);
      launch(16'd65534, 16'd0, 11'd4, 11'd1);
      wait_idle(50);

      // Reset mid-tile
      exp_tile(16'd200, 16'd16, 8, 2);
      d0 = done_cnt;
      launch(16'd200, 16'd16, 11'd8, 11'd2);
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_addr", {read_addr_a, read_addr_b}, 0);
      chk("rst_mid_outs", {out_valid, out_data_a, out_data_b, out_b_valid, out_eol, out_last, busy, done}, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (out_valid || busy || done) seen = 1'b1;
      end
      chk("post_reset_quiet", seen, 0);
      chk("rst_no_done", done_cnt - d0, 0);
      exp_pair(16'd300, 16'd301, 1, 0, 0);
      exp_pair(16'd302, 16'd303, 1, 1, 1);
      launch(16'd300, 16'd5, 11'd4, 11'd1);
      wait_idle(50);

      // Back-to-back: start during the done cycle
      exp_pair(16'd40, 16'd41, 1, 1, 1);
      launch(16'd40, 16'd0, 11'd2, 11'd1);
      n = 0;
      while (!done && n < 20) begin tick(); n++; end
      chk("b2b_first_done", done, 1);
      exp_pair(16'd50, 16'd51, 1, 1, 1);
      launch(16'd50, 16'd0, 11'd2, 11'd1);
      chk("b2b_accept", busy, 1);
      wait_idle(50);

      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
